// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream switching blocks: the arbiter FSM
// state type and the index-width helper used to size stream selectors.
package axis_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // A selector for a single stream still needs one bit to stay a legal vector.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_rr_arb.sv
// Combinational round-robin pick: first asserted request scanning upward from
// the slot after last_idx_i, wrapping around, so the previous winner goes last.
module axis_rr_arb
  import axis_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idxWidth(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_idx_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int off = 1; off <= N; off++) begin
      if (!found_o && req_i[(int'(last_idx_i) + off) % N]) begin
        found_o = 1'b1;
        idx_o   = IW'((int'(last_idx_i) + off) % N);
      end
    end
  end

endmodule

// File: rtl/axis_arb_mux.sv
// Frame-aware round-robin AXI-Stream mux: a grant lasts one whole frame, and
// the granted stream feeds a two-entry (main + skid) registered output stage.
module axis_arb_mux
  import axis_pkg::*;
#(
  parameter int S_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
  parameter int LAST_ENABLE = 1,
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 0,
  parameter int USER_WIDTH  = 1,
  parameter int IW          = idxWidth(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*ID_WIDTH-1:0]   s_axis_tid,
  input  logic [S_COUNT*DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic [DEST_WIDTH-1:0]         m_axis_tdest,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic                          grant_valid,
  output logic [IW-1:0]                 grant_idx
);

  localparam int BW = DATA_WIDTH + KEEP_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1;
  localparam logic [BW-1:0] RESET_BEAT =
    (KEEP_ENABLE != 0) ? '0 : (BW'({KEEP_WIDTH{1'b1}}) << DATA_WIDTH);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grantIdx_q, grantIdx_d;
  logic [IW-1:0] lastIdx_q, lastIdx_d;
  logic          arbFound;
  logic [IW-1:0] arbIdx;

  logic [DATA_WIDTH-1:0] inData;
  logic [KEEP_WIDTH-1:0] inKeep;
  logic [ID_WIDTH-1:0]   inId;
  logic [DEST_WIDTH-1:0] inDest;
  logic [USER_WIDTH-1:0] inUser;
  logic                  inLast, inValid, inFire;
  logic [BW-1:0]         inBeat;

  logic          inReady_q;
  logic          mainValid_q, mainValid_d, skidValid_q, skidValid_d;
  logic [BW-1:0] mainBeat_q, mainBeat_d, skidBeat_q, skidBeat_d;

  axis_rr_arb #(.N(S_COUNT), .IW(IW)) uArb (
    .req_i      (s_axis_tvalid),
    .last_idx_i (lastIdx_q),
    .found_o    (arbFound),
    .idx_o      (arbIdx)
  );

  // Disabled sidebands are forced here so both buffer entries carry constants.
  always_comb begin
    inData  = s_axis_tdata[int'(grantIdx_q)*DATA_WIDTH +: DATA_WIDTH];
    inKeep  = (KEEP_ENABLE != 0) ? s_axis_tkeep[int'(grantIdx_q)*KEEP_WIDTH +: KEEP_WIDTH] : '1;
    inId    = (ID_ENABLE != 0) ? s_axis_tid[int'(grantIdx_q)*ID_WIDTH +: ID_WIDTH] : '0;
    inDest  = (DEST_ENABLE != 0) ? s_axis_tdest[int'(grantIdx_q)*DEST_WIDTH +: DEST_WIDTH] : '0;
    inUser  = (USER_ENABLE != 0) ? s_axis_tuser[int'(grantIdx_q)*USER_WIDTH +: USER_WIDTH] : '0;
    inLast  = (LAST_ENABLE != 0) ? s_axis_tlast[grantIdx_q] : 1'b1;
    inValid = (state_q == BUSY) && s_axis_tvalid[grantIdx_q];
    inFire  = inValid && inReady_q;
    inBeat  = {inLast, inUser, inDest, inId, inKeep, inData};
  end

  always_comb begin
    state_d    = state_q;
    grantIdx_d = grantIdx_q;
    lastIdx_d  = lastIdx_q;
    case (state_q)
      IDLE: begin
        if (arbFound) begin
          state_d    = BUSY;
          grantIdx_d = arbIdx;
        end
      end
      BUSY: begin
        if (inFire && inLast) begin
          state_d   = IDLE;
          lastIdx_d = grantIdx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    if (state_q == BUSY) begin
      s_axis_tready[grantIdx_q] = inReady_q;
    end
  end

  // The skid entry only fills while main is stalled, and it always drains first.
  always_comb begin
    mainValid_d = mainValid_q;
    skidValid_d = skidValid_q;
    mainBeat_d  = mainBeat_q;
    skidBeat_d  = skidBeat_q;
    if (!mainValid_q || m_axis_tready) begin
      if (skidValid_q) begin
        mainBeat_d  = skidBeat_q;
        mainValid_d = 1'b1;
        skidValid_d = 1'b0;
      end else if (inFire) begin
        mainBeat_d  = inBeat;
        mainValid_d = 1'b1;
      end else begin
        mainValid_d = 1'b0;
      end
    end else if (inFire) begin
      skidBeat_d  = inBeat;
      skidValid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grantIdx_q  <= '0;
      lastIdx_q   <= IW'(S_COUNT - 1);
      inReady_q   <= 1'b1;
      mainValid_q <= 1'b0;
      skidValid_q <= 1'b0;
      mainBeat_q  <= RESET_BEAT;
      skidBeat_q  <= RESET_BEAT;
    end else begin
      state_q     <= state_d;
      grantIdx_q  <= grantIdx_d;
      lastIdx_q   <= lastIdx_d;
      inReady_q   <= !skidValid_d;
      mainValid_q <= mainValid_d;
      skidValid_q <= skidValid_d;
      mainBeat_q  <= mainBeat_d;
      skidBeat_q  <= skidBeat_d;
    end
  end

  assign {m_axis_tlast, m_axis_tuser, m_axis_tdest, m_axis_tid, m_axis_tkeep, m_axis_tdata} = mainBeat_q;
  assign m_axis_tvalid = mainValid_q;
  assign grant_valid   = (state_q == BUSY);
  assign grant_idx     = grantIdx_q;

endmodule

// File: tb/tb_axis_arb_mux.sv
// Randomized scoreboard bench for axis_arb_mux: a frame-level reference model
// predicts grants and expected output beats; monitors compare independently.
module tb_axis_arb_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep, s_tvalid, s_tready, s_tlast, s_tuser;
  logic [31:0] s_tid, s_tdest;
  logic [7:0]  m_tdata, m_tid, m_tdest;
  logic [0:0]  m_tkeep, m_tuser;
  logic        m_tvalid, m_tready, m_tlast, grant_valid;
  logic [1:0]  grant_idx;

  logic [31:0] s1_tdata;
  logic [3:0]  s1_tvalid, s1_tready, s1_tlast;
  logic [7:0]  m1_tdata, m1_tid, m1_tdest;
  logic [0:0]  m1_tkeep, m1_tuser;
  logic        m1_tvalid, m1_tready, m1_tlast, grant1_valid;
  logic [1:0]  grant1_idx;

  int testsRun = 0;
  int testsFailed = 0;

  // Per-stream pending beats: bit 8 is tlast, bits 7:0 are data.
  logic [8:0] strmQ[4][$];
  logic [8:0] expQ[$];
  logic [8:0] exp1Q[$];
  logic [3:0] pauseMask = '0;
  logic       readyCtl = 1'b1;
  bit         randReady = 1'b0;
  bit         mdlBusy = 1'b0;
  int         mdlGrant = 0;
  int         mdlLast = 3;
  int         inFlight = 0;

  always #5 clk = ~clk;

  axis_arb_mux #(.S_COUNT(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  axis_arb_mux #(.S_COUNT(4), .DATA_WIDTH(8), .LAST_ENABLE(0)) dutNoLast (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s1_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s1_tvalid),
    .s_axis_tready(s1_tready), .s_axis_tlast(s1_tlast), .s_axis_tid(s_tid),
    .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m1_tdata), .m_axis_tkeep(m1_tkeep), .m_axis_tvalid(m1_tvalid),
    .m_axis_tready(m1_tready), .m_axis_tlast(m1_tlast), .m_axis_tid(m1_tid),
    .m_axis_tdest(m1_tdest), .m_axis_tuser(m1_tuser),
    .grant_valid(grant1_valid), .grant_idx(grant1_idx)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportFail(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: got timeout/extra beat expected none at %0t", name, $time);
  endtask

  task automatic applyStimulus(input int s, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) begin
      strmQ[s].push_back({(k == len - 1) ? 1'b1 : 1'b0, 8'(base + 8'(k))});
    end
  endtask

  task automatic driveInputs();
    for (int i = 0; i < 4; i++) begin
      s_tvalid[i] = (strmQ[i].size() > 0) && !pauseMask[i];
      if (strmQ[i].size() > 0) begin
        s_tdata[i*8 +: 8] = strmQ[i][0][7:0];
        s_tlast[i]        = strmQ[i][0][8];
      end else begin
        s_tdata[i*8 +: 8] = 8'($urandom);
        s_tlast[i]        = 1'b0;
      end
    end
    m_tready = randReady ? ($urandom_range(0, 3) != 0) : readyCtl;
  endtask

  // Driver plus frame-level model: the model grants whole frames round-robin
  // among the streams the bench itself is presenting as valid.
  initial begin
    logic [3:0] acc;
    logic [3:0] allowed;
    forever begin
      @(negedge clk);
      acc = '0;
      if (!rst) begin
        allowed = mdlBusy ? (4'b0001 << mdlGrant) : 4'b0000;
        checkOutput("grant_valid", grant_valid, mdlBusy);
        if (mdlBusy) checkOutput("grant_idx", grant_idx, mdlGrant);
        checkOutput("tready_gate", s_tready & ~allowed, 0);
        checkOutput("occupancy_le2", (inFlight <= 2), 1);
        if (inFlight == 2) checkOutput("full_stall", s_tready, 0);
        acc = s_tvalid & s_tready;
        inFlight += $countones(acc) - ((m_tvalid && m_tready) ? 1 : 0);
        if (!mdlBusy) begin
          for (int off = 1; off <= 4 && !mdlBusy; off++) begin
            if (s_tvalid[(mdlLast + off) % 4]) begin
              mdlBusy  = 1'b1;
              mdlGrant = (mdlLast + off) % 4;
            end
          end
          if (mdlBusy) begin
            for (int j = 0; j < strmQ[mdlGrant].size(); j++) begin
              expQ.push_back(strmQ[mdlGrant][j]);
              if (strmQ[mdlGrant][j][8]) break;
            end
          end
        end else if (acc[mdlGrant] && s_tlast[mdlGrant]) begin
          mdlBusy = 1'b0;
          mdlLast = mdlGrant;
        end
      end
      @(posedge clk);
      #1;
      if (!rst) begin
        for (int i = 0; i < 4; i++) if (acc[i]) void'(strmQ[i].pop_front());
      end
      driveInputs();
    end
  end

  // Output monitor for the main instance.
  initial begin
    logic       prevStall = 1'b0;
    logic [8:0] prevBeat = '0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall) begin
          checkOutput("hold_valid", m_tvalid, 1);
          checkOutput("hold_beat", {m_tlast, m_tdata}, prevBeat);
        end
        if (m_tvalid) begin
          checkOutput("tkeep_ones", m_tkeep, 1);
          checkOutput("sideband_zero", {m_tid, m_tdest, m_tuser}, 0);
        end
        if (m_tvalid && m_tready) begin
          if (expQ.size() == 0) reportFail("unexpected_beat");
          else begin
            e = expQ.pop_front();
            checkOutput("out_beat", {m_tlast, m_tdata}, e);
          end
        end
        prevStall = m_tvalid && !m_tready;
        prevBeat  = {m_tlast, m_tdata};
      end
    end
  end

  // Output monitor for the LAST_ENABLE=0 instance.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst && m1_tvalid && m1_tready) begin
        if (exp1Q.size() == 0) reportFail("nolast_unexpected_beat");
        else begin
          e = exp1Q.pop_front();
          checkOutput("nolast_beat", {m1_tlast, m1_tdata}, e);
        end
      end
    end
  end

  task automatic waitIdle(input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      #1;
      done = !mdlBusy && inFlight == 0 && expQ.size() == 0 &&
             strmQ[0].size() == 0 && strmQ[1].size() == 0 &&
             strmQ[2].size() == 0 && strmQ[3].size() == 0;
    end
    if (!done) reportFail("drain_timeout");
  endtask

  task automatic resetMidFrame();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rst_m_tvalid", m_tvalid, 0);
    checkOutput("rst_grant_valid", grant_valid, 0);
    checkOutput("rst_s_tready", s_tready, 0);
    for (int i = 0; i < 4; i++) strmQ[i].delete();
    expQ.delete();
    mdlBusy = 1'b0;
    mdlLast = 3;
    inFlight = 0;
    pauseMask = '0;
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    int k0 = 0;
    int k3 = 0;
    logic [3:0] acc1;
    s_tkeep = '1; s_tid = '1; s_tdest = '1; s_tuser = '1;
    s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
    s1_tdata = '0; s1_tvalid = '0; s1_tlast = '0; m1_tready = 1'b1;
    #23;
    checkOutput("reset_m_tvalid", m_tvalid, 0);
    checkOutput("reset_grant", {grant_valid, grant_idx}, 0);
    checkOutput("reset_s_tready", s_tready, 0);
    checkOutput("reset_m_tdata", {m_tlast, m_tdata}, 0);
    checkOutput("reset_m_tkeep", m_tkeep, 1);
    @(posedge clk);
    #3;
    rst = 1'b0;

    // Single requester, three-beat frame.
    applyStimulus(2, 3, 8'hA1);
    waitIdle(50);

    // All four streams, two-beat frames each.
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < 4; s++) applyStimulus(s, 2, 8'((s << 4) | (f << 1)));
    waitIdle(200);

    // Output backpressure mid-frame.
    applyStimulus(1, 6, 8'h60);
    repeat (3) @(posedge clk);
    readyCtl = 1'b0;
    repeat (5) @(posedge clk);
    readyCtl = 1'b1;
    waitIdle(100);

    // Granted stream pauses while stream 1 requests.
    applyStimulus(3, 4, 8'h70);
    applyStimulus(1, 2, 8'h80);
    repeat (3) @(posedge clk);
    pauseMask = 4'b1000;
    repeat (3) @(posedge clk);
    pauseMask = 4'b0000;
    waitIdle(100);

    // Random frames with random output readiness.
    randReady = 1'b1;
    for (int f = 0; f < 30; f++)
      applyStimulus($urandom_range(0, 3), $urandom_range(1, 4), 8'($urandom));
    waitIdle(2000);
    randReady = 1'b0;

    // Reset with two beats buffered, then stream 0 must win first.
    readyCtl = 1'b0;
    applyStimulus(1, 8, 8'h90);
    repeat (8) @(posedge clk);
    checkOutput("buffered_two", inFlight, 2);
    resetMidFrame();
    readyCtl = 1'b1;
    applyStimulus(2, 2, 8'hA0);
    applyStimulus(0, 2, 8'hB0);
    waitIdle(100);

    // LAST_ENABLE=0: streams 0 and 3 alternate every beat, tlast always 1.
    for (int k = 0; k < 8; k++) begin
      exp1Q.push_back({1'b1, 8'(k)});
      exp1Q.push_back({1'b1, 8'(8'h30 + k)});
    end
    for (int c = 0; c < 200 && exp1Q.size() > 0; c++) begin
      @(negedge clk);
      acc1 = s1_tvalid & s1_tready;
      @(posedge clk);
      #1;
      if (acc1[0]) k0++;
      if (acc1[3]) k3++;
      s1_tvalid[0] = (k0 < 8);
      s1_tdata[7:0] = 8'(k0);
      s1_tvalid[3] = (k3 < 8);
      s1_tdata[31:24] = 8'(8'h30 + k3);
    end
    if (exp1Q.size() != 0) reportFail("nolast_timeout");
    s1_tvalid = '0;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
